// File: rtl/uart_tx_channel_arbiter.sv
// Round-robin arbiter sharing one UART Tx core between N_CH channels, holding the grant for a whole packet.
// Optional clear-to-send gating is enabled by defining UART_TX_ARB_CTS_EN.
module uart_tx_channel_arbiter #(
  parameter int N_CH      = 4,
  parameter int MAX_BYTES = 16,
  localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH-1:0]   ch_empty,
  input  logic              core_r_en,
`ifdef UART_TX_ARB_CTS_EN
  input  logic              usr_cts,
`endif
  output logic              prot_txen,
  output logic              prot_empty,
  output logic [1:0]        frame_sel,
  output logic [N_CH-1:0]   gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [N_CH-1:0]   ch_r_en,
  output logic              pkt_done
);

  // state  | meaning
  // S_IDLE | no grant; arbitrate among requesters
  // S_ADDR | slave-address frame of the granted channel
  // S_DATA | data frames popped from the granted FIFO
  // S_STOP | stop frame; grant released when accepted
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_STOP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             win_vld;
  logic [CNT_W-1:0] byte_cnt;
  logic             cts;
  logic             eff_empty;
  logic             pop;
  int               cand;

`ifdef UART_TX_ARB_CTS_EN
  assign cts = usr_cts;
`else
  assign cts = 1'b1;
`endif

  // First requester after the last winner wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand     = (int'(rr_ptr) + k) % N_CH;
      cand_idx = IDX_W'(cand);
      if (!win_vld && ch_req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Dropping CTS closes the packet like an empty FIFO would.
  assign eff_empty = ch_empty[gnt_idx] | (byte_cnt == CNT_W'(MAX_BYTES)) | ~cts;
  assign pop       = (state == S_DATA) && core_r_en && !eff_empty;

  always_comb begin
    state_nxt  = state;
    prot_txen  = 1'b0;
    prot_empty = 1'b0;
    frame_sel  = 2'd0;
    ch_r_en    = '0;
    case (state)
      S_IDLE: begin
        if (win_vld && cts) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        prot_txen = 1'b1;
        if (core_r_en) state_nxt = S_DATA;
      end
      S_DATA: begin
        prot_txen  = 1'b1;
        frame_sel  = 2'd1;
        prot_empty = eff_empty;
        if (eff_empty) state_nxt = S_STOP;
        if (pop) ch_r_en[gnt_idx] = 1'b1;
      end
      S_STOP: begin
        prot_txen  = 1'b1;
        frame_sel  = 2'd2;
        prot_empty = 1'b1;
        if (core_r_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge glb_clk) begin
    if (!glb_rstn) begin
      state    <= S_IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      byte_cnt <= '0;
      pkt_done <= 1'b0;
      rr_ptr   <= IDX_W'(N_CH - 1);
    end else begin
      state    <= state_nxt;
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld && cts) begin
            gnt      <= N_CH'(1) << win_idx;
            gnt_idx  <= win_idx;
            rr_ptr   <= win_idx;
            byte_cnt <= '0;
          end
        end
        S_DATA: begin
          if (pop) byte_cnt <= byte_cnt + 1'b1;
        end
        S_STOP: begin
          if (core_r_en) begin
            gnt      <= '0;
            pkt_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_channel_arbiter.sv
// Scoreboard bench for uart_tx_channel_arbiter: expected grants and frames are queued, then
// popped as the DUT accepts frames. Define UART_TX_ARB_CTS_EN to include the CTS scenario.
module tb_uart_tx_channel_arbiter;
  localparam int N_CH = 4;
  localparam int MAX_BYTES = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] ch_req;
  logic [3:0] ch_empty;
  logic       core_r_en;
`ifdef UART_TX_ARB_CTS_EN
  logic       usr_cts;
`endif
  logic       prot_txen;
  logic       prot_empty;
  logic [1:0] frame_sel;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic [3:0] ch_r_en;
  logic       pkt_done;

  always #5 clk = ~clk;

  uart_tx_channel_arbiter #(.N_CH(N_CH), .MAX_BYTES(MAX_BYTES)) dut (
    .glb_clk    (clk),
    .glb_rstn   (rstn),
    .ch_req     (ch_req),
    .ch_empty   (ch_empty),
    .core_r_en  (core_r_en),
`ifdef UART_TX_ARB_CTS_EN
    .usr_cts    (usr_cts),
`endif
    .prot_txen  (prot_txen),
    .prot_empty (prot_empty),
    .frame_sel  (frame_sel),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .ch_r_en    (ch_r_en),
    .pkt_done   (pkt_done)
  );

  int checks = 0;
  int failures = 0;
  int fifo_cnt[4];
  int pops[4];
  int done_cnt;
  int rr_model;
  logic [3:0] prev_gnt = 4'd0;
  int exp_frame_q[$];
  int exp_gnt_q[$];

  function automatic int rr_pick(input logic [3:0] req, input int rr);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (rr + k) % 4;
      if (req[2'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic push_gnt(input logic [3:0] req);
    rr_model = rr_pick(req, rr_model);
    exp_gnt_q.push_back(rr_model);
  endtask

  task automatic push_packet(input int ndata);
    exp_frame_q.push_back(0);
    for (int i = 0; i < ndata; i++) exp_frame_q.push_back(1);
    exp_frame_q.push_back(2);
  endtask

  // Runs the FIFO model and core pulses until npkts pkt_done pulses, or stop_pops pops.
  task automatic run(input int max_cyc, input int period, input int npkts, input int stop_pops);
    bit finished;
    int total;
    int e;
    finished = 1'b0;
    total = 0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) pops[i] = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      core_r_en = ((cyc % period) == (period - 1));
      for (int i = 0; i < 4; i++) ch_empty[i] = (fifo_cnt[i] == 0);
      #1;
      if (ch_r_en != 4'd0) begin
        checks++;
        if ((ch_r_en & ~gnt) != 4'd0 || frame_sel !== 2'd1 || $countones(ch_r_en) != 1) begin
          failures++;
          $display("FAIL ch_r_en_legal: ch_r_en=%b gnt=%b frame_sel=%0d", ch_r_en, gnt, frame_sel);
        end
      end
      if (gnt != 4'd0 && prev_gnt == 4'd0) begin
        checks++;
        if (exp_gnt_q.size() == 0) begin
          failures++;
          $display("FAIL grant_order: unexpected grant gnt=%b", gnt);
        end else begin
          e = exp_gnt_q.pop_front();
          if (gnt !== 4'(1 << e) || gnt_idx !== 2'(e)) begin
            failures++;
            $display("FAIL grant_order: got gnt=%b idx=%0d expected ch%0d", gnt, gnt_idx, e);
          end
        end
      end
      prev_gnt = gnt;
      if (core_r_en && prot_txen && !(frame_sel == 2'd1 && prot_empty)) begin
        checks++;
        if (exp_frame_q.size() == 0) begin
          failures++;
          $display("FAIL frame_seq: unexpected frame_sel=%0d", frame_sel);
        end else begin
          e = exp_frame_q.pop_front();
          if (frame_sel !== 2'(e)) begin
            failures++;
            $display("FAIL frame_seq: got frame_sel=%0d expected %0d", frame_sel, e);
          end
        end
        if (frame_sel == 2'd2) begin
          checks++;
          if (prot_empty !== 1'b1) begin
            failures++;
            $display("FAIL stop_empty: got prot_empty=%b expected 1", prot_empty);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (ch_r_en[i]) begin
          pops[i]++;
          fifo_cnt[i]--;
          total++;
        end
      end
      if (pkt_done) begin
        done_cnt++;
        checks++;
        if (gnt !== 4'd0) begin
          failures++;
          $display("FAIL gnt_release: got gnt=%b with pkt_done expected 0000", gnt);
        end
      end
      if (npkts > 0 && done_cnt >= npkts) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk);
      if (stop_pops > 0 && total >= stop_pops) begin
        finished = 1'b1;
        break;
      end
    end
    core_r_en = 1'b0;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL run_timeout: got done=%0d pops=%0d expected done=%0d pops=%0d",
               done_cnt, total, npkts, stop_pops);
    end
    checks++;
    if (exp_frame_q.size() != 0 || exp_gnt_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d frames %0d grants left expected 0 0",
               exp_frame_q.size(), exp_gnt_q.size());
    end
    exp_frame_q.delete();
    exp_gnt_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ch_req = 4'hF;
    ch_empty = 4'h0;
    core_r_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'd0 || gnt_idx !== 2'd0 || pkt_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: got gnt=%b idx=%0d done=%b expected 0 0 0", gnt, gnt_idx, pkt_done);
    end
    checks++;
    if (prot_txen !== 1'b0 || prot_empty !== 1'b0 || frame_sel !== 2'd0 || ch_r_en !== 4'd0) begin
      failures++;
      $display("FAIL reset_comb: got txen=%b empty=%b sel=%0d r_en=%b expected all 0",
               prot_txen, prot_empty, frame_sel, ch_r_en);
    end
    rstn = 1'b1;
    ch_req = 4'h0;
    core_r_en = 1'b0;
    rr_model = N_CH - 1;
    @(posedge clk);
  endtask

  task automatic test_single_packet();
    for (int i = 0; i < 4; i++) fifo_cnt[i] = 0;
    fifo_cnt[0] = 3;
    push_gnt(4'b0001);
    push_packet(3);
    @(negedge clk);
    ch_req = 4'b0001;
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL grant_latency: got gnt=%b expected 0001", gnt);
    end
    run(200, 4, 1, 0);
    ch_req = 4'b0000;
    checks++;
    if (pops[0] != 3 || done_cnt != 1) begin
      failures++;
      $display("FAIL single_pops: got pops=%0d done=%0d expected 3 1", pops[0], done_cnt);
    end
  endtask

  task automatic test_round_robin();
    fifo_cnt[0] = 3;
    fifo_cnt[2] = 3;
    for (int p = 0; p < 4; p++) begin
      push_gnt(4'b0101);
      push_packet((p < 2) ? 3 : 0);
    end
    @(negedge clk);
    ch_req = 4'b0101;
    run(600, 3, 4, 0);
    ch_req = 4'b0000;
    checks++;
    if (pops[0] != 3 || pops[2] != 3) begin
      failures++;
      $display("FAIL rr_pops: got ch0=%0d ch2=%0d expected 3 3", pops[0], pops[2]);
    end
  endtask

  task automatic test_max_bytes();
    fifo_cnt[1] = 20;
    push_gnt(4'b0010);
    push_packet(MAX_BYTES);
    push_gnt(4'b0010);
    push_packet(20 - MAX_BYTES);
    @(negedge clk);
    ch_req = 4'b0010;
    run(1000, 2, 2, 0);
    ch_req = 4'b0000;
    checks++;
    if (pops[1] != 20 || done_cnt != 2) begin
      failures++;
      $display("FAIL max_bytes_pops: got pops=%0d done=%0d expected 20 2", pops[1], done_cnt);
    end
  endtask

  task automatic test_empty_channel();
    fifo_cnt[3] = 0;
    push_gnt(4'b1000);
    push_packet(0);
    @(negedge clk);
    ch_req = 4'b1000;
    run(200, 4, 1, 0);
    ch_req = 4'b0000;
    checks++;
    if (pops[3] != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL empty_pops: got pops=%0d done=%0d expected 0 1", pops[3], done_cnt);
    end
  endtask

  task automatic test_reset_mid_data();
    fifo_cnt[0] = 10;
    fifo_cnt[2] = 4;
    push_gnt(4'b0101);
    exp_frame_q.push_back(0);
    for (int i = 0; i < 5; i++) exp_frame_q.push_back(1);
    @(negedge clk);
    ch_req = 4'b0101;
    run(300, 2, 0, 5);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'd0 || prot_txen !== 1'b0 || pkt_done !== 1'b0 || gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: got gnt=%b txen=%b done=%b idx=%0d expected 0 0 0 0",
               gnt, prot_txen, pkt_done, gnt_idx);
    end
    @(negedge clk);
    rstn = 1'b1;
    prev_gnt = 4'd0;
    rr_model = N_CH - 1;
    push_gnt(4'b0101);
    push_packet(5);
    run(300, 2, 1, 0);
    ch_req = 4'b0000;
    checks++;
    if (pops[0] != 5 || fifo_cnt[0] != 0) begin
      failures++;
      $display("FAIL post_reset_pops: got pops=%0d left=%0d expected 5 0", pops[0], fifo_cnt[0]);
    end
  endtask

`ifdef UART_TX_ARB_CTS_EN
  task automatic test_cts();
    fifo_cnt[1] = 10;
    @(negedge clk);
    usr_cts = 1'b0;
    ch_req = 4'b0010;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'd0 || prot_txen !== 1'b0) begin
      failures++;
      $display("FAIL cts_block: got gnt=%b txen=%b expected 0000 0", gnt, prot_txen);
    end
    push_gnt(4'b0010);
    exp_frame_q.push_back(0);
    exp_frame_q.push_back(1);
    exp_frame_q.push_back(1);
    @(negedge clk);
    usr_cts = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL cts_grant: got gnt=%b expected 0010", gnt);
    end
    run(200, 2, 0, 2);
    @(negedge clk);
    usr_cts = 1'b0;
    exp_frame_q.push_back(2);
    run(200, 2, 1, 0);
    ch_req = 4'b0000;
    checks++;
    if (pops[1] != 0 || done_cnt != 1 || fifo_cnt[1] != 8) begin
      failures++;
      $display("FAIL cts_close: got pops=%0d done=%0d left=%0d expected 0 1 8",
               pops[1], done_cnt, fifo_cnt[1]);
    end
    usr_cts = 1'b1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    ch_req = 4'h0;
    ch_empty = 4'hF;
    core_r_en = 1'b0;
    rr_model = N_CH - 1;
    for (int i = 0; i < 4; i++) fifo_cnt[i] = 0;
`ifdef UART_TX_ARB_CTS_EN
    usr_cts = 1'b1;
`endif
    test_reset();
    test_single_packet();
    test_round_robin();
    test_max_bytes();
    test_empty_channel();
    test_reset_mid_data();
`ifdef UART_TX_ARB_CTS_EN
    test_cts();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
